mio_arbiter: RTL and testbench
==============================

# mio_arbiter

Two-master memory arbiter between the multicycle CPU controller's memory port and a read-only device fetch port (display refresh / DMA), sharing one single-port RAM. Issues one word access at a time to the RAM, waits a fixed latency, returns read data, and pulses a per-requester ready. The CPU side supplies the `MIO_ready` the controller waits on in its IF, MEM_RD and MEM_WD states.

## Interface
Parameters:
- `MEM_AW`, 10: RAM word-address width; `mem_addr = addr[MEM_AW+1:2]`.
- `MEM_LAT`, 1: cycles from the `mem_en` cycle to `mem_rdata` valid; legal range 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  CPU access request (MemRead|MemWrite), held until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  byte address, word-aligned.
- `cpu_wdata`  in  32  write data.
- `cpu_rdata`  out  32  read data, valid in the `cpu_ready` cycle and held until the next CPU read completes.
- `cpu_ready`  out  1  one-cycle completion pulse (MIO_ready).
- `dev_req`  in  1  device read request, held until `dev_ready`.
- `dev_addr`  in  32  byte address, word-aligned.
- `dev_rdata`  out  32  read data, valid in the `dev_ready` cycle, held after.
- `dev_ready`  out  1  one-cycle completion pulse.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  1  RAM write enable, qualified by `mem_en`.
- `mem_addr`  out  MEM_AW  RAM word address.
- `mem_wdata`  out  32  RAM write data.
- `mem_rdata`  in  32  RAM read data.
- `owner`  out  1  current or most recent grant: 0 = CPU, 1 = device.
- `state_out`  out  2  FSM state, for debug.

## Operation
- States: IDLE=0, ACCESS=1, WAIT=2, DONE=3. All outputs are registered.
- IDLE:
  - With no request, remain in IDLE.
  - With a request, pick the winner, latch its addr/we/wdata into the mem_* registers, set `owner`, and go to ACCESS.
- Arbitration is round-robin over a `last` bit.
  - If only one master requests, that master is granted.
  - If both request, the master not equal to `last` is granted.
  - `last` updates on each grant.
  - Reset value of `last` is device, so the CPU wins the first tie.
- ACCESS:
  - `mem_en`=1 for exactly this cycle; `mem_we`=`cpu_we` for a CPU grant and 0 for a device grant.
  - Load `cnt`=MEM_LAT, then go to WAIT.
- WAIT:
  - While `cnt`>1, decrement `cnt`.
  - When `cnt`==1, capture `mem_rdata` into the owner's rdata register (reads only), pulse the owner's ready for the next cycle, and go to DONE.
- DONE:
  - The ready pulse is high in this cycle.
  - Requests are ignored in this cycle, because the requester is still holding req.
  - Go to IDLE.
- Writes leave `cpu_rdata` unchanged.
- Device requests are always reads; `dev_we` does not exist.
- The address is truncated to `[MEM_AW+1:2]`; address bits [1:0] and the upper bits are ignored.

## Timing
- Request sampled in IDLE at cycle r gives:
  - `mem_en` high in cycle r+1;
  - ready high in cycle r+MEM_LAT+2.
- Example, MEM_LAT=1: 3 cycles from request seen to ready.
- After its ready pulse, a requester must drop req by the following cycle; a req still high in IDLE starts a new access.
- Minimum spacing between consecutive accesses is MEM_LAT+3 cycles.
- A req deasserted mid-access (protocol violation): the access still completes and ready still pulses.
- Reset values, applied on the clock edge after `reset` is sampled high:
  - state=IDLE, `cnt`=0, `last`=1, `owner`=0;
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` = 0;
  - both ready outputs = 0, both rdata outputs = 0.
- Reset mid-operation: any in-flight access is abandoned, with no ready pulse and `mem_en` low from the next cycle. A write already strobed in ACCESS is not undone.
- Requests arriving outside IDLE wait; they are neither lost nor queued beyond the held req level.

## Structure
- Shared header `mio_defs.vh`:
  - state encodings `MIO_IDLE`/`MIO_ACCESS`/`MIO_WAIT`/`MIO_DONE`;
  - owner constants `OWN_CPU`=0, `OWN_DEV`=1.
- One natural sub-module, `rr_pick2`: combinational two-input round-robin chooser (req_a, req_b, last → grant, valid). Everything else stays in the top FSM.

## Test plan
- Reset: hold `reset` 2 cycles mid-stream → all outputs 0, `state_out`=0. First tie after release is granted to the CPU.
- CPU read, MEM_LAT=1: RAM word 0x10 = 0xDEADBEEF; `cpu_req` with addr 0x40, we=0, at cycle 0 →
  - `mem_en` high only in cycle 1, with `mem_addr`=0x10, `mem_we`=0;
  - `cpu_ready` high only in cycle 3, with `cpu_rdata`=0xDEADBEEF.
- CPU write then read: write 0x12345678 to 0x44 → single `mem_we` cycle. A later read of 0x44 returns 0x12345678; `cpu_rdata` is unchanged during the write.
- Contention: `cpu_req` and `dev_req` held high continuously → grants alternate CPU, dev, CPU, dev. `owner` toggles each access; neither master is starved.
- Latency sweep, MEM_LAT=4: device read → ready exactly 6 cycles after req is sampled, `dev_rdata` correct. Repeat with MEM_LAT=15 → 17 cycles.
- Reset in WAIT, MEM_LAT=4: assert `reset` in the second WAIT cycle → no ready pulse, `state_out`=0 next cycle. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/mio_arbiter_pkg.sv
// Shared state encodings and owner constants for the CPU/device memory arbiter.
package mio_arbiter_pkg;

  typedef enum logic [1:0] {
    MIO_IDLE   = 2'd0,
    MIO_ACCESS = 2'd1,
    MIO_WAIT   = 2'd2,
    MIO_DONE   = 2'd3
  } mio_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DEV = 1'b1;

endpackage

// File: rtl/mio_arbiter_rr_pick2.sv
// Two-input round-robin chooser: a tie goes to the master that was not granted last.
module rr_pick2
  import mio_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req_a | req_b;
    if (req_a && req_b) grant = ~last;
    else                grant = req_b ? OWN_DEV : OWN_CPU;
  end

endmodule

// File: rtl/mio_arbiter.sv
// Two-master (CPU read/write, device read-only) arbiter in front of one single-port RAM
// with a fixed read latency; one word access at a time, per-requester ready pulse.
module mio_arbiter
  import mio_arbiter_pkg::*;
#(
  parameter int MEM_AW  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              dev_req,
  input  logic [31:0]       dev_addr,
  output logic [31:0]       dev_rdata,
  output logic              dev_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              owner,
  output logic [1:0]        state_out
);

  mio_state_t state;
  logic [3:0] cnt;
  logic       last;
  logic       acc_we;
  logic       pick_grant;
  logic       pick_valid;
  logic       unused_addr;

  assign unused_addr = ^{cpu_addr[31:MEM_AW+2], cpu_addr[1:0],
                         dev_addr[31:MEM_AW+2], dev_addr[1:0]};

  rr_pick2 u_pick (
    .req_a (cpu_req),
    .req_b (dev_req),
    .last  (last),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign state_out = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MIO_IDLE;
      cnt       <= '0;
      last      <= OWN_DEV;
      owner     <= OWN_CPU;
      acc_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ready <= 1'b0;
      dev_ready <= 1'b0;
      cpu_rdata <= '0;
      dev_rdata <= '0;
    end else begin
      case (state)
        MIO_IDLE: begin
          // Strobe is registered here so it is high throughout the ACCESS cycle.
          if (pick_valid) begin
            owner  <= pick_grant;
            last   <= pick_grant;
            mem_en <= 1'b1;
            if (pick_grant == OWN_CPU) begin
              mem_we    <= cpu_we;
              acc_we    <= cpu_we;
              mem_addr  <= cpu_addr[MEM_AW+1:2];
              mem_wdata <= cpu_wdata;
            end else begin
              mem_we   <= 1'b0;
              acc_we   <= 1'b0;
              mem_addr <= dev_addr[MEM_AW+1:2];
            end
            state <= MIO_ACCESS;
          end
        end
        MIO_ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= 4'(MEM_LAT);
          state  <= MIO_WAIT;
        end
        MIO_WAIT: begin
          if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (owner == OWN_DEV) begin
              dev_rdata <= mem_rdata;
              dev_ready <= 1'b1;
            end else begin
              if (!acc_we) cpu_rdata <= mem_rdata;
              cpu_ready <= 1'b1;
            end
            state <= MIO_DONE;
          end
        end
        MIO_DONE: begin
          cpu_ready <= 1'b0;
          dev_ready <= 1'b0;
          state     <= MIO_IDLE;
        end
        default: state <= MIO_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// Bench for mio_arbiter: three instances (MEM_LAT 1, 4, 15), each with its own RAM model,
// checked cycle by cycle against a transaction-level reference model.
module tb_mio_arbiter;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic [2:0]  cpu_req, cpu_we, cpu_ready, dev_req, dev_ready, mem_en, mem_we, owner;
  logic [31:0] cpu_addr  [3];
  logic [31:0] cpu_wdata [3];
  logic [31:0] cpu_rdata [3];
  logic [31:0] dev_addr  [3];
  logic [31:0] dev_rdata [3];
  logic [9:0]  mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic [1:0]  state_out [3];

  // Reference model state
  logic [31:0] ref_mem [3][1024];
  logic [31:0] model_cpu_rd [3];
  logic [31:0] model_dev_rd [3];
  logic        model_last [3];

  function automatic logic [31:0] init_word(input int a);
    logic [31:0] w;
    w = 32'(a) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
    if (a == 16) w = 32'hDEAD_BEEF;
    return w;
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 15;
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 4 : 15;
    logic [31:0] ram  [1024];
    logic [31:0] pipe [LAT];

    initial for (int a = 0; a < 1024; a++) ram[a] = init_word(a);

    // Non-read slots carry junk so a capture at the wrong cycle shows up as bad data.
    always @(posedge clk) begin
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? ram[mem_addr[g]] : (32'hBAD0_0000 | 32'(cyc));
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
      if (mem_en[g] && mem_we[g]) ram[mem_addr[g]] = mem_wdata[g];
    end
    assign mem_rdata[g] = pipe[LAT-1];

    mio_arbiter #(.MEM_AW(10), .MEM_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we[g]),
      .cpu_addr  (cpu_addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_rdata (cpu_rdata[g]),
      .cpu_ready (cpu_ready[g]),
      .dev_req   (dev_req[g]),
      .dev_addr  (dev_addr[g]),
      .dev_rdata (dev_rdata[g]),
      .dev_ready (dev_ready[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .owner     (owner[g]),
      .state_out (state_out[g])
    );
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      model_cpu_rd[i] = '0;
      model_dev_rd[i] = '0;
      model_last[i]   = 1'b1;
    end
  endtask

  // One single-master access, checked every cycle from grant to the following IDLE cycle.
  task automatic run_access(input int i, input bit dev, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int          lat;
    bit          is_wr;
    logic [9:0]  wi;
    logic [31:0] exp_rd;
    logic [1:0]  exp_st;
    lat    = lat_of(i);
    is_wr  = !dev && we;
    wi     = addr[11:2];
    exp_rd = ref_mem[i][wi];
    if (dev) begin
      dev_req[i] = 1'b1; dev_addr[i] = addr;
    end else begin
      cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_addr[i] = addr; cpu_wdata[i] = wdata;
    end
    for (int k = 1; k <= lat + 3; k++) begin
      step();
      exp_st = (k == 1) ? 2'd1 : (k <= lat + 1) ? 2'd2 : (k == lat + 2) ? 2'd3 : 2'd0;
      n_checks++;
      if (state_out[i] !== exp_st) begin
        n_fail++; $display("FAIL %s state k=%0d: got %0d want %0d", tag, k, state_out[i], exp_st);
      end
      n_checks++;
      if (mem_en[i] !== (k == 1)) begin
        n_fail++; $display("FAIL %s mem_en k=%0d: got %b want %b", tag, k, mem_en[i], k == 1);
      end
      n_checks++;
      if (cpu_ready[i] !== (!dev && k == lat + 2)) begin
        n_fail++; $display("FAIL %s cpu_ready k=%0d: got %b want %b", tag, k, cpu_ready[i], !dev && k == lat + 2);
      end
      n_checks++;
      if (dev_ready[i] !== (dev && k == lat + 2)) begin
        n_fail++; $display("FAIL %s dev_ready k=%0d: got %b want %b", tag, k, dev_ready[i], dev && k == lat + 2);
      end
      if (k == 1) begin
        n_checks++;
        if (mem_addr[i] !== wi) begin
          n_fail++; $display("FAIL %s mem_addr: got %h want %h", tag, mem_addr[i], wi);
        end
        n_checks++;
        if (mem_we[i] !== is_wr || owner[i] !== dev) begin
          n_fail++; $display("FAIL %s we/owner: got %b/%b want %b/%b", tag, mem_we[i], owner[i], is_wr, dev);
        end
        if (is_wr) begin
          n_checks++;
          if (mem_wdata[i] !== wdata) begin
            n_fail++; $display("FAIL %s mem_wdata: got %h want %h", tag, mem_wdata[i], wdata);
          end
        end
      end
      if (k == lat + 2) begin
        if (dev) model_dev_rd[i] = exp_rd;
        else if (!we) model_cpu_rd[i] = exp_rd;
        cpu_req[i] = 1'b0;
        dev_req[i] = 1'b0;
      end
      n_checks++;
      if (cpu_rdata[i] !== model_cpu_rd[i] || dev_rdata[i] !== model_dev_rd[i]) begin
        n_fail++; $display("FAIL %s rdata k=%0d: got cpu %h dev %h want cpu %h dev %h", tag, k,
                           cpu_rdata[i], dev_rdata[i], model_cpu_rd[i], model_dev_rd[i]);
      end
    end
    if (is_wr) ref_mem[i][wi] = wdata;
    model_last[i] = dev;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({mem_en[i], mem_we[i], mem_addr[i], mem_wdata[i], cpu_ready[i], dev_ready[i],
           cpu_rdata[i], dev_rdata[i], owner[i], state_out[i]} !== '0) begin
        n_fail++;
        $display("FAIL %s inst%0d: got en=%b we=%b a=%h wd=%h rdy=%b%b crd=%h drd=%h own=%b st=%0d want all 0",
                 tag, i, mem_en[i], mem_we[i], mem_addr[i], mem_wdata[i], cpu_ready[i], dev_ready[i],
                 cpu_rdata[i], dev_rdata[i], owner[i], state_out[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    model_reset();
    check_all_zero("power_up_reset");
    run_access(0, 1'b0, 1'b0, 32'h0000_0040, '0, "pre_reset_read");
    // Mid-stream reset during an access on instance 0
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h0000_0048;
    step();
    reset = 1'b1; cpu_req[0] = 1'b0;
    step();
    check_all_zero("reset_cycle1");
    step();
    check_all_zero("reset_cycle2");
    reset = 1'b0;
    model_reset();
    // First tie after reset goes to the CPU
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h0000_0080;
    dev_req[0] = 1'b1; dev_addr[0] = 32'h0000_00C0;
    step();
    n_checks++;
    if (owner[0] !== 1'b0 || mem_en[0] !== 1'b1 || mem_addr[0] !== 10'h20) begin
      n_fail++; $display("FAIL tie_after_reset: got own=%b en=%b a=%h want 0/1/020", owner[0], mem_en[0], mem_addr[0]);
    end
    step(); step();
    n_checks++;
    if (cpu_ready[0] !== 1'b1 || dev_ready[0] !== 1'b0 || cpu_rdata[0] !== ref_mem[0][32]) begin
      n_fail++; $display("FAIL tie_ready: got rdy=%b/%b rd=%h want 1/0 %h", cpu_ready[0], dev_ready[0], cpu_rdata[0], ref_mem[0][32]);
    end
    cpu_req[0] = 1'b0; dev_req[0] = 1'b0;
    model_cpu_rd[0] = ref_mem[0][32];
    model_last[0]   = 1'b0;
    step();
  endtask

  task automatic test_cpu_read();
    run_access(0, 1'b0, 1'b0, 32'h0000_0040, '0, "cpu_read_deadbeef");
    n_checks++;
    if (cpu_rdata[0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL cpu_read_value: got %h want deadbeef", cpu_rdata[0]);
    end
  endtask

  task automatic test_write_read();
    run_access(0, 1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, "cpu_write");
    run_access(0, 1'b1, 1'b0, 32'h0000_0100, '0, "dev_between");
    run_access(0, 1'b0, 1'b0, 32'h0000_0044, '0, "cpu_readback");
    n_checks++;
    if (cpu_rdata[0] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL readback_value: got %h want 12345678", cpu_rdata[0]);
    end
  endtask

  task automatic test_contention();
    logic [31:0] ca, da;
    logic        exp_own;
    logic [31:0] exp_rd;
    int          t_prev;
    bit          seen;
    ca = 32'h0000_0104; da = 32'h0000_0208;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = ca;
    dev_req[0] = 1'b1; dev_addr[0] = da;
    t_prev = -1;
    for (int n = 0; n < 4; n++) begin
      exp_own = ~model_last[0];
      seen = 0;
      for (int w = 0; w < 8 && !seen; w++) begin
        step();
        if (mem_en[0] === 1'b1) seen = 1;
      end
      n_checks++;
      if (!seen) begin
        n_fail++; $display("FAIL contention_grant%0d: got no mem_en want mem_en within 8 cycles", n);
      end
      n_checks++;
      if (owner[0] !== exp_own || mem_addr[0] !== (exp_own ? da[11:2] : ca[11:2])) begin
        n_fail++; $display("FAIL contention_owner%0d: got own=%b a=%h want own=%b", n, owner[0], mem_addr[0], exp_own);
      end
      if (t_prev >= 0) begin
        n_checks++;
        if (cyc - t_prev !== lat_of(0) + 3) begin
          n_fail++; $display("FAIL contention_spacing%0d: got %0d want %0d", n, cyc - t_prev, lat_of(0) + 3);
        end
      end
      t_prev = cyc;
      model_last[0] = exp_own;
      exp_rd = ref_mem[0][exp_own ? da[11:2] : ca[11:2]];
      seen = 0;
      for (int w = 0; w < 8 && !seen; w++) begin
        step();
        if (cpu_ready[0] === 1'b1 || dev_ready[0] === 1'b1) seen = 1;
      end
      if (exp_own) model_dev_rd[0] = exp_rd; else model_cpu_rd[0] = exp_rd;
      n_checks++;
      if (!seen || cpu_ready[0] !== ~exp_own || dev_ready[0] !== exp_own ||
          cpu_rdata[0] !== model_cpu_rd[0] || dev_rdata[0] !== model_dev_rd[0]) begin
        n_fail++; $display("FAIL contention_ready%0d: got rdy=%b/%b rd=%h/%h want rdy=%b/%b rd=%h/%h", n,
                           cpu_ready[0], dev_ready[0], cpu_rdata[0], dev_rdata[0],
                           ~exp_own, exp_own, model_cpu_rd[0], model_dev_rd[0]);
      end
      if (n == 3) begin cpu_req[0] = 1'b0; dev_req[0] = 1'b0; end
    end
    step(); step();
    n_checks++;
    if (state_out[0] !== 2'd0 || mem_en[0] !== 1'b0) begin
      n_fail++; $display("FAIL contention_idle: got st=%0d en=%b want 0/0", state_out[0], mem_en[0]);
    end
  endtask

  task automatic test_latency();
    run_access(1, 1'b1, 1'b0, 32'h0000_0040, '0, "dev_lat4");
    run_access(1, 1'b0, 1'b0, {$urandom_range(0, 1023), 2'b00}, '0, "cpu_lat4");
    run_access(2, 1'b1, 1'b0, {$urandom_range(0, 1023), 2'b00}, '0, "dev_lat15");
    run_access(2, 1'b0, 1'b1, 32'h0000_0010, $urandom, "cpu_wr_lat15");
    run_access(2, 1'b1, 1'b0, 32'h0000_0010, '0, "dev_rd_after_wr_lat15");
  endtask

  task automatic test_reset_in_wait();
    dev_req[1] = 1'b1; dev_addr[1] = 32'h0000_0300;
    step(); step(); step();
    reset = 1'b1; dev_req[1] = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (state_out[1] !== 2'd0 || dev_ready[1] !== 1'b0 || mem_en[1] !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_wait: got st=%0d rdy=%b en=%b want 0/0/0", state_out[1], dev_ready[1], mem_en[1]);
    end
    for (int w = 0; w < 6; w++) begin
      step();
      n_checks++;
      if (dev_ready[1] !== 1'b0 || state_out[1] !== 2'd0) begin
        n_fail++; $display("FAIL reset_no_ready w=%0d: got rdy=%b st=%0d want 0/0", w, dev_ready[1], state_out[1]);
      end
    end
    run_access(1, 1'b1, 1'b0, 32'h0000_0300, '0, "fresh_after_reset");
  endtask

  task automatic test_random();
    int          i;
    bit          dev, we;
    logic [31:0] addr;
    for (int n = 0; n < 24; n++) begin
      i    = $urandom_range(0, 1);
      dev  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      run_access(i, dev, we, addr, $urandom, "random");
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    reset = 1'b1;
    cpu_req = '0; cpu_we = '0; dev_req = '0;
    for (int i = 0; i < 3; i++) begin
      cpu_addr[i] = '0; cpu_wdata[i] = '0; dev_addr[i] = '0;
      for (int a = 0; a < 1024; a++) ref_mem[i][a] = init_word(a);
    end
    model_reset();
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_write_read();
    test_contention();
    test_latency();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
